fetch_buffered: RTL and testbench
=================================

Name: fetch_buffered

Overview:
Parametrised successor to the current fetch/PC stage. Holds the fetch PC, issues one instruction-memory request at a time over a valid/ready handshake, and buffers returned instructions with their PCs in a DEPTH-entry queue toward decode. Redirects (exception, branch, jump) are prioritised, flush the queue, and discard any in-flight stale response. Sits between the imem port and the decode stage.

Parameters:
ADDR_W, 32, width of PC and addresses
INSTR_W, 32, instruction width
DEPTH, 4, instruction queue entries (power of 2, >=2)
PC_STEP, 4, sequential PC increment
RESET_PC, 32'h0000_0000, fetch PC after reset
EXC_VECTOR, 32'h0000_0080, exception redirect target

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
is_exception  in  1  redirect to EXC_VECTOR
is_branch  in  1  redirect to pc_branch
is_jump  in  1  redirect to pc_jump
pc_branch  in  ADDR_W  branch target
pc_jump  in  ADDR_W  jump target
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  request address
imem_resp_valid  in  1  response valid (one per accepted request, >=1 cycle later)
imem_resp_data  in  INSTR_W  returned instruction
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  INSTR_W  head instruction
out_pc  out  ADDR_W  head PC

Behaviour:
- Reset (synchronous, active-high): fetch_pc=RESET_PC, queue empty, state IDLE, no outstanding request; out_valid=0, imem_req_valid=0 during reset cycle; out_instr/out_pc=0.
- Redirect priority: exception > branch > jump; redirect = any of the three high. Target loads into fetch_pc at the next edge.
- States: IDLE (no request outstanding), WAIT (one outstanding, valid), DROP (one outstanding, stale).
- imem_req_valid = (state==IDLE) && !redirect && (count < DEPTH); imem_req_addr = fetch_pc. Only one request outstanding ever; the count<DEPTH gate guarantees the response has a free slot.
- Request accept (valid&&ready): req_pc<=fetch_pc, fetch_pc+=PC_STEP (wraps modulo 2^ADDR_W), IDLE->WAIT.
- WAIT + imem_resp_valid: push {req_pc, imem_resp_data}; ->IDLE. A request may issue in the same cycle the response arrives is NOT allowed (IDLE required); max throughput 1 instr per 2 cycles with 1-cycle memory.
- Redirect in any cycle: queue flushed (count=0 next cycle; simultaneous pop/push that cycle ignored); WAIT->DROP; DROP stays DROP; IDLE stays IDLE. Redirect coinciding with a response in WAIT: response discarded, ->IDLE.
- DROP + imem_resp_valid: data discarded, ->IDLE.
- imem_resp_valid in IDLE: ignored.
- Queue: out_valid=(count!=0), head registered; pop on out_valid&&out_ready; push and pop same cycle leaves count unchanged; pointers wrap modulo DEPTH.
- Latency: response at edge k -> out_valid=1 in cycle k+1 (queue was empty). First request issues the cycle after reset deasserts.
- Reset mid-operation overrides everything including redirects and pending responses; a response arriving after reset in IDLE is ignored.

Decomposition:
- Shared define file: state encodings (IDLE/WAIT/DROP), default RESET_PC and EXC_VECTOR values.
- One sub-module: fetch_fifo (synchronous FIFO, width ADDR_W+INSTR_W, DEPTH, flush input, count output).

Test Plan:
- Reset release, memory ready=1, 1-cycle response -> requests at 0x0,0x4,0x8 on alternate cycles; out_pc sequence 0x0,0x4,0x8 with matching instr.
- out_ready=0, DEPTH=4 -> exactly 4 requests accepted, imem_req_valid=0 afterwards; out_ready=1 resumes at 0x10.
- is_branch with pc_branch=0x100 while WAIT -> queue empty next cycle, late response dropped, next request addr 0x100.
- is_exception, is_branch, is_jump same cycle -> next request addr EXC_VECTOR (0x80).
- Redirect in same cycle as response, plus out_ready with non-empty queue -> nothing pushed, count=0, state IDLE.
- fetch_pc=0xFFFF_FFFC accepted -> next request addr 0x0; reset asserted while WAIT -> out_valid=0, stray response ignored, first request at RESET_PC.

Source files
------------

// File: rtl/fetch_buffered_pkg.sv
// Shared definitions for the buffered fetch stage: FSM state encoding and
// default reset / exception vectors.
package fetch_buffered_pkg;

  // IDLE: nothing outstanding; WAIT: one live request; DROP: one stale request
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

  // Width of an occupancy counter able to hold 0..depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_buffered_if.sv
// Bundles the imem request/response port and the decode-side queue port.
// master = fetch stage, slave = memory + decode environment.
interface fetch_buffered_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, out_ready
  );
endinterface

// File: rtl/fetch_buffered_fifo.sv
// Synchronous FIFO with flush and occupancy count; holds {pc, instr} pairs
// between the imem response and decode.
module fetch_fifo
  import fetch_buffered_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i  && (count_q != '0);

  // Storage write
  // NOTE: the entries have no reset; nothing reads a slot before it is
  // written, so only the pointers and count need a defined reset value.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy update; flush wins over a same-cycle push/pop
  // NOTE: sequential state uses <= so every register sees pre-edge values,
  // regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CNT_W'(1);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_buffered.sv
// Fetch/PC stage: one imem request in flight at a time, redirects with
// exception > branch > jump priority, responses queued toward decode.
module fetch_buffered
  import fetch_buffered_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                INSTR_W    = 32,
  parameter int                DEPTH      = 4,
  parameter int                PC_STEP    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_exception,
  input  logic              is_branch,
  input  logic              is_jump,
  input  logic [ADDR_W-1:0] pc_branch,
  input  logic [ADDR_W-1:0] pc_jump,
  fetch_buffered_if.master  bus
);

  localparam int CNT_W = count_width(DEPTH);

  fetch_state_e               state_q, state_d;
  logic [ADDR_W-1:0]          fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]          req_pc_q;
  logic [ADDR_W-1:0]          redirect_pc;
  logic                       redirect;
  logic                       req_fire;
  logic                       push, pop;
  logic [CNT_W-1:0]           count;
  logic [ADDR_W+INSTR_W-1:0]  head;

  assign redirect = is_exception || is_branch || is_jump;

  // Redirect target selection, highest priority first
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    redirect_pc = fetch_pc_q;
    if (is_exception)   redirect_pc = EXC_VECTOR;
    else if (is_branch) redirect_pc = pc_branch;
    else if (is_jump)   redirect_pc = pc_jump;
  end

  // Only issue from IDLE with a guaranteed free slot for the response
  assign bus.imem_req_valid = !reset && (state_q == ST_IDLE) && !redirect &&
                              (count < CNT_W'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // A live response is queued unless a redirect makes it stale this cycle
  assign push = (state_q == ST_WAIT) && bus.imem_resp_valid && !redirect;
  assign pop  = bus.out_valid && bus.out_ready;

  // Next state and next fetch PC
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      ST_IDLE: if (req_fire) state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.imem_resp_valid) state_d = ST_IDLE;
        else if (redirect)       state_d = ST_DROP;
      end
      ST_DROP: if (bus.imem_resp_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (redirect)      fetch_pc_d = redirect_pc;
    else if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
  end

  // State, fetch PC and in-flight request PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (req_fire) req_pc_q <= fetch_pc_q;
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_i (reset),
    .flush_i (redirect),
    .push_i  (push),
    .data_i  ({req_pc_q, bus.imem_resp_data}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count)
  );

  assign bus.out_valid = !reset && (count != '0);
  assign bus.out_pc    = bus.out_valid ? head[ADDR_W+INSTR_W-1:INSTR_W] : '0;
  assign bus.out_instr = bus.out_valid ? head[INSTR_W-1:0] : '0;

endmodule

// File: tb/tb_fetch_buffered.sv
// Randomised bench for fetch_buffered against a transaction-level model:
// expected PC, an "in flight / stale" flag pair and a queue of {pc, instr}.
module tb_fetch_buffered;

  localparam int          ADDR_W     = 32;
  localparam int          INSTR_W    = 32;
  localparam int          DEPTH      = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        is_exception = 1'b0, is_branch = 1'b0, is_jump = 1'b0;
  logic [31:0] pc_branch = '0, pc_jump = '0;

  fetch_buffered_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  fetch_buffered #(
    .ADDR_W     (ADDR_W),
    .INSTR_W    (INSTR_W),
    .DEPTH      (DEPTH),
    .PC_STEP    (4),
    .RESET_PC   (RESET_PC),
    .EXC_VECTOR (EXC_VECTOR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .is_exception (is_exception),
    .is_branch    (is_branch),
    .is_jump      (is_jump),
    .pc_branch    (pc_branch),
    .pc_jump      (pc_jump),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model
  entry_t      mq[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_req_pc = '0;
  bit          m_busy = 0, m_stale = 0;

  // Memory environment: one pending response with random latency
  bit mem_pend = 0;
  int mem_cnt = 0;

  // Stimulus knobs (percentages and max latency)
  int p_ready = 100, p_out = 100, p_redir = 0, p_rst = 0, max_lat = 1;

  function automatic logic [31:0] rand_target();
    case ($urandom_range(3))
      0:       return 32'h0000_0100;
      1:       return 32'hFFFF_FFF8;
      2:       return $urandom & 32'hFFFF_FFFC;
      default: return 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic cycle(input bit force_rst);
    bit          rst, redir, exp_rv, exp_ov, fire_dut;
    logic [2:0]  rsel;
    logic [31:0] tgt;
    entry_t      e;

    @(negedge clk);
    rst   = force_rst || ($urandom_range(999) < p_rst);
    reset = rst;
    bus.imem_req_ready = ($urandom_range(99) < p_ready);
    bus.out_ready      = ($urandom_range(99) < p_out);
    rsel = ($urandom_range(99) < p_redir) ? 3'($urandom_range(1, 7)) : 3'b000;
    is_exception = rsel[2];
    is_branch    = rsel[1];
    is_jump      = rsel[0];
    pc_branch    = rand_target();
    pc_jump      = rand_target();
    bus.imem_resp_valid = mem_pend && (mem_cnt == 0);
    bus.imem_resp_data  = $urandom;
    #1;

    redir  = is_exception || is_branch || is_jump;
    tgt    = is_exception ? EXC_VECTOR : (is_branch ? pc_branch : pc_jump);
    exp_rv = !rst && !m_busy && !redir && (mq.size() < DEPTH);
    exp_ov = !rst && (mq.size() != 0);

    check("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
    if (exp_rv) check("req_addr", 64'(bus.imem_req_addr), 64'(m_pc));
    check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    e = exp_ov ? mq[0] : '0;
    check("out_pc", 64'(bus.out_pc), 64'(e.pc));
    check("out_instr", 64'(bus.out_instr), 64'(e.instr));

    // Memory environment reacts to what the DUT actually did
    fire_dut = bus.imem_req_valid && bus.imem_req_ready;
    if (bus.imem_resp_valid) mem_pend = 0;
    else if (mem_pend) mem_cnt = rst ? 0 : mem_cnt - 1;
    if (fire_dut) begin
      mem_pend = 1;
      mem_cnt  = $urandom_range(max_lat - 1);
    end

    // Model update for the coming edge
    if (rst) begin
      mq.delete();
      m_pc    = RESET_PC;
      m_busy  = 0;
      m_stale = 0;
    end else if (redir) begin
      mq.delete();
      m_pc = tgt;
      if (m_busy && bus.imem_resp_valid) begin
        m_busy  = 0;
        m_stale = 0;
      end else if (m_busy) begin
        m_stale = 1;
      end
    end else begin
      if (exp_ov && bus.out_ready) void'(mq.pop_front());
      if (m_busy && bus.imem_resp_valid) begin
        if (!m_stale) mq.push_back('{pc: m_req_pc, instr: bus.imem_resp_data});
        m_busy  = 0;
        m_stale = 0;
      end
      if (exp_rv && bus.imem_req_ready) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
        m_busy   = 1;
        m_stale  = 0;
      end
    end
  endtask

  initial begin
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.out_ready       = 1'b0;

    // Reset, then streaming with always-ready memory and decode
    repeat (3) cycle(1'b1);
    repeat (30) cycle(1'b0);

    // Decode stalled: queue fills to DEPTH and requests stop, then drain
    p_out = 0;
    repeat (20) cycle(1'b0);
    p_out = 100;
    repeat (20) cycle(1'b0);

    // Mixed random traffic with redirects, variable latency and resets
    p_ready = 70; p_out = 60; p_redir = 8; p_rst = 5; max_lat = 3;
    repeat (3000) cycle(1'b0);

    // Heavy redirect pressure, including simultaneous redirect sources
    p_redir = 30; p_out = 80; p_rst = 0;
    repeat (500) cycle(1'b0);

    // Reset mid-operation followed by quiet traffic
    p_redir = 0;
    repeat (5) cycle(1'b0);
    cycle(1'b1);
    repeat (40) cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
